// File: rtl/sysbus_mem_responder_if.sv
// ----------------------------------------------------------------------------
// sysbus_mem_responder_if
// System bus bundle between the fetch/load initiator and a memory responder.
//   bus_reqcyc  : initiator request/data beat valid
//   bus_req     : header address or write data
//   bus_reqtag  : request tag {rw, device[3:0], id[7:0]}
//   bus_reqack  : responder accepted the current request/data beat
//   bus_respcyc : responder read beat valid
//   bus_resp    : read data beat
//   bus_resptag : echo of the accepted read tag
//   bus_respack : initiator consumed the current read beat
// Modports: master (initiator side), slave (responder side).
// ----------------------------------------------------------------------------
interface sysbus_mem_responder_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13
) ();
    logic              bus_reqcyc;
    logic [DATA_W-1:0] bus_req;
    logic [TAG_W-1:0]  bus_reqtag;
    logic              bus_reqack;
    logic              bus_respcyc;
    logic [DATA_W-1:0] bus_resp;
    logic [TAG_W-1:0]  bus_resptag;
    logic              bus_respack;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/sysbus_mem_responder.sv
// ----------------------------------------------------------------------------
// sysbus_mem_responder
// Memory-side slave on the system bus. Accepts one line request at a time:
// reads return 8 beats (64 bytes) in ascending word order after READ_LATENCY
// idle cycles; writes consume 8 data beats into the internal array.
// Ports:
//   clk       : clock
//   reset     : synchronous, active-low reset (memory contents are kept)
//   bus       : sysbus_mem_responder_if.slave bundle
//   proto_err : sticky protocol-violation flag (only with SYSBUS_PROTO_CHECK_EN)
// Optional feature macro: SYSBUS_PROTO_CHECK_EN
// ----------------------------------------------------------------------------
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'h0
`endif

module sysbus_mem_responder #(
    parameter int         BUS_DATA_WIDTH = 64,
    parameter int         BUS_TAG_WIDTH  = 13,
    parameter logic [3:0] DEVICE_ID      = `SYSBUS_MEMORY,
    parameter int         MEM_WORDS      = 4096,
    parameter int         READ_LATENCY   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    sysbus_mem_responder_if.slave   bus
`ifdef SYSBUS_PROTO_CHECK_EN
    ,
    output logic                    proto_err
`endif
);

    localparam int AW     = $clog2(MEM_WORDS);
    localparam int LINE_W = AW - 3;
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WDATA = 2'd1;
    localparam logic [1:0] ST_LAT   = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]                state_q,   state_d;
    logic [2:0]                beat_q,    beat_d;
    logic [LAT_W-1:0]          lat_q,     lat_d;
    logic [LINE_W-1:0]         line_q,    line_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q,     tag_d;
    logic                      reqack_q,  reqack_d;
    logic                      respcyc_q, respcyc_d;
    logic [BUS_DATA_WIDTH-1:0] resp_q,    resp_d;
    logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;

    logic [BUS_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic dev_match_s;
    logic is_read_s;
    logic wr_en_s;
    logic unused_bits_s;

    assign dev_match_s = (bus.bus_reqtag[11:8] == DEVICE_ID);
    assign is_read_s   = bus.bus_reqtag[BUS_TAG_WIDTH-1];
    // The reset cycle must never commit a data beat into the array.
    assign wr_en_s     = reset && (state_q == ST_WDATA) && bus.bus_reqcyc;
    // Address bits above the array depth alias; the 6 byte-offset bits are ignored.
    assign unused_bits_s = ^{bus.bus_req[BUS_DATA_WIDTH-1:AW+3], bus.bus_req[5:0]};

    assign bus.bus_reqack  = reqack_q;
    assign bus.bus_respcyc = respcyc_q;
    assign bus.bus_resp    = resp_q;
    assign bus.bus_resptag = resptag_q;

    // Next-state logic for the request/response sequencer.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        line_d    = line_q;
        tag_d     = tag_q;
        reqack_d  = 1'b0;
        respcyc_d = respcyc_q;
        resp_d    = resp_q;
        resptag_d = resptag_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.bus_reqcyc && dev_match_s) begin
                    line_d   = bus.bus_req[AW+2:6];
                    tag_d    = bus.bus_reqtag;
                    reqack_d = 1'b1;
                    beat_d   = 3'd0;
                    lat_d    = {LAT_W{1'b0}};
                    state_d  = is_read_s ? ST_LAT : ST_WDATA;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (bus.bus_reqcyc) begin
                    reqack_d = 1'b1;
                    beat_d   = beat_q + 3'd1;
                    state_d  = (beat_q == 3'd7) ? ST_IDLE : ST_WDATA;
                end else begin
                    state_d  = ST_WDATA;
                end
            end
            ST_LAT: begin
                // Counts READ_LATENCY full cycles after the ack cycle.
                if (lat_q == LAT_W'(READ_LATENCY)) begin
                    state_d   = ST_RESP;
                    beat_d    = 3'd0;
                    respcyc_d = 1'b1;
                    resp_d    = mem_q[{line_q, 3'd0}];
                    resptag_d = tag_q;
                end else begin
                    lat_d     = lat_q + LAT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.bus_respack) begin
                    if (beat_q == 3'd7) begin
                        respcyc_d = 1'b0;
                        beat_d    = 3'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        beat_d    = beat_q + 3'd1;
                        resp_d    = mem_q[{line_q, beat_q + 3'd1}];
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                respcyc_d = 1'b0;
            end
        endcase
    end

    // Sequencer and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            beat_q    <= 3'd0;
            lat_q     <= {LAT_W{1'b0}};
            line_q    <= {LINE_W{1'b0}};
            tag_q     <= {BUS_TAG_WIDTH{1'b0}};
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= {BUS_DATA_WIDTH{1'b0}};
            resptag_q <= {BUS_TAG_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            line_q    <= line_d;
            tag_q     <= tag_d;
            reqack_q  <= reqack_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[{line_q, beat_q}] <= bus.bus_req;
        end
    end

`ifdef SYSBUS_PROTO_CHECK_EN
    logic                     proto_err_q;
    logic                     pend_q;
    logic [BUS_TAG_WIDTH-1:0] pend_tag_q;
    logic                     viol_s;

    // Detects respack outside RESP, tag change on a held unacked request,
    // and misaligned read headers.
    always_comb begin
        viol_s = 1'b0;
        if (bus.bus_respack && (state_q != ST_RESP)) begin
            viol_s = 1'b1;
        end else if ((state_q == ST_IDLE) && bus.bus_reqcyc && pend_q &&
                     (bus.bus_reqtag != pend_tag_q)) begin
            viol_s = 1'b1;
        end else if ((state_q == ST_IDLE) && bus.bus_reqcyc && dev_match_s &&
                     is_read_s && (bus.bus_req[5:0] != 6'd0)) begin
            viol_s = 1'b1;
        end else begin
            viol_s = 1'b0;
        end
    end

    // Sticky error flag plus memory of an unacked request held in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            proto_err_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_tag_q  <= {BUS_TAG_WIDTH{1'b0}};
        end else begin
            proto_err_q <= proto_err_q | viol_s;
            pend_q      <= (state_q == ST_IDLE) && bus.bus_reqcyc && !dev_match_s;
            pend_tag_q  <= bus.bus_reqtag;
        end
    end

    assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_sysbus_mem_responder
// Randomized self-checking bench: a word-addressed reference memory predicts
// every read beat, expected beats are queued at request time and a monitor
// pops and compares them whenever a beat is handed over on the bus.
// ----------------------------------------------------------------------------
module tb_sysbus_mem_responder;

    localparam int         DW        = 64;
    localparam int         TW        = 13;
    localparam int         MEM_WORDS = 4096;
    localparam int         RL        = 4;
    localparam logic [3:0] DEV       = 4'h0;

    typedef struct {
        logic [63:0] data;
        logic [12:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sysbus_mem_responder_if #(.DATA_W(DW), .TAG_W(TW)) bus ();
`ifdef SYSBUS_PROTO_CHECK_EN
    logic proto_err;
`endif

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH(DW),
        .BUS_TAG_WIDTH (TW),
        .DEVICE_ID     (DEV),
        .MEM_WORDS     (MEM_WORDS),
        .READ_LATENCY  (RL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef SYSBUS_PROTO_CHECK_EN
        ,
        .proto_err(proto_err)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        e;
    logic [63:0] model_mem [longint];
    logic [63:0] lines[$];
    int          beats_done = 0;
    int          stall_left = 0;
    int          stall_beat = 2;
    logic        force_ack  = 1'b0;
    logic        pend_v     = 1'b0;
    logic [63:0] pend_d;
    logic [12:0] pend_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Word index of a beat: line number times 8 plus beat, modulo the depth.
    function automatic longint widx(input logic [63:0] addr, input int beat);
        return longint'(((addr / 64'd64) * 64'd8 + 64'(beat)) % 64'(MEM_WORDS));
    endfunction

    // Initiator respack: random back-pressure, plus a forced stall on one beat.
    always @(posedge clk) begin
        #2;
        if (force_ack) begin
            bus.bus_respack = 1'b1;
        end else if (bus.bus_respcyc) begin
            if (stall_left > 0 && beats_done == stall_beat) begin
                bus.bus_respack = 1'b0;
                stall_left--;
            end else begin
                bus.bus_respack = ($urandom_range(0, 3) != 0);
            end
        end else begin
            bus.bus_respack = 1'b0;
        end
    end

    // Monitor: stability while stalled, and scoreboard compare on each handover.
    always @(negedge clk) begin
        if (reset && bus.bus_respcyc) begin
            if (pend_v) begin
                check("stall_resp_stable", bus.bus_resp, pend_d);
                check("stall_tag_stable", 64'(bus.bus_resptag), 64'(pend_t));
            end
            if (bus.bus_respack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got 0x%0h, expected no beat", bus.bus_resp);
                end else begin
                    e = sb.pop_front();
                    check("resp_data", bus.bus_resp, e.data);
                    check("resp_tag", 64'(bus.bus_resptag), 64'(e.tag));
                end
                beats_done++;
                pend_v = 1'b0;
            end else begin
                pend_v = 1'b1;
                pend_d = bus.bus_resp;
                pend_t = bus.bus_resptag;
            end
        end else begin
            pend_v = 1'b0;
        end
    end

    task automatic do_write(input logic [63:0] addr, input logic [63:0] d [8], input logic [7:0] id);
        bus.bus_reqcyc = 1'b1;
        bus.bus_req    = addr;
        bus.bus_reqtag = {1'b0, DEV, id};
        @(posedge clk); #1;
        check("wr_hdr_ack", 64'(bus.bus_reqack), 64'd1);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 1)) begin
                bus.bus_reqcyc = 1'b0;
                @(posedge clk); #1;
                check("wr_gap_noack", 64'(bus.bus_reqack), 64'd0);
            end
            bus.bus_reqcyc = 1'b1;
            bus.bus_req    = d[i];
            @(posedge clk); #1;
            check("wr_beat_ack", 64'(bus.bus_reqack), 64'd1);
            model_mem[widx(addr, i)] = d[i];
        end
        bus.bus_reqcyc = 1'b0;
        bus.bus_req    = 64'd0;
    endtask

    // Header phase of a read: queue the 8 expected beats, check ack and latency.
    task automatic issue_read(input logic [63:0] addr, input logic [7:0] id);
        exp_t        x;
        int          k;
        logic [12:0] tag;
        tag        = {1'b1, DEV, id};
        beats_done = 0;
        for (int b = 0; b < 8; b++) begin
            x.data = model_mem[widx(addr, b)];
            x.tag  = tag;
            sb.push_back(x);
        end
        bus.bus_reqcyc = 1'b1;
        bus.bus_req    = addr;
        bus.bus_reqtag = tag;
        @(posedge clk); #1;
        check("rd_hdr_ack", 64'(bus.bus_reqack), 64'd1);
        bus.bus_reqcyc = 1'b0;
        bus.bus_req    = 64'd0;
        k = 0;
        while (!bus.bus_respcyc && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("rd_latency", 64'(k), 64'(RL + 1));
    endtask

    task automatic finish_read();
        int k;
        k = 0;
        while ((sb.size() != 0 || bus.bus_respcyc) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check("rd_all_beats", 64'(sb.size()), 64'd0);
        check("rd_respcyc_low", 64'(bus.bus_respcyc), 64'd0);
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [7:0] id);
        issue_read(addr, id);
        finish_read();
    endtask

    task automatic check_reset_outputs();
        check("rst_reqack", 64'(bus.bus_reqack), 64'd0);
        check("rst_respcyc", 64'(bus.bus_respcyc), 64'd0);
        check("rst_resp", bus.bus_resp, 64'd0);
        check("rst_resptag", 64'(bus.bus_resptag), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] d [8];
        logic [63:0] a;
        int          k;

        reset          = 1'b0;
        bus.bus_reqcyc = 1'b0;
        bus.bus_req    = 64'd0;
        bus.bus_reqtag = 13'd0;
        bus.bus_respack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed line: 0x11..0x88, then read back with tag 0x1005.
        for (int i = 0; i < 8; i++) d[i] = 64'(8'h11) * 64'(i + 1);
        do_write(64'h1000, d, 8'h01);
        do_read(64'h1000, 8'h05);

        // Beat 2 held for 3 cycles by the initiator.
        stall_left = 3;
        stall_beat = 2;
        do_read(64'h1000, 8'h06);
        check("stall_applied", 64'(stall_left), 64'd0);

        // Foreign device: never acked, responder stays idle.
        bus.bus_reqcyc = 1'b1;
        bus.bus_req    = 64'h1000;
        bus.bus_reqtag = {1'b1, 4'h3, 8'h77};
        repeat (20) begin
            @(posedge clk); #1;
            check("foreign_noack", 64'(bus.bus_reqack), 64'd0);
        end
        bus.bus_reqcyc = 1'b0;
        bus.bus_req    = 64'd0;
        check("foreign_norespcyc", 64'(bus.bus_respcyc), 64'd0);

        // Low bits ignored, and depth aliasing.
        do_read(64'h1038, 8'h07);
        do_read(64'(MEM_WORDS) * 64'd8 + 64'h1000, 8'h08);

        // Random lines written then read back, some through aliases.
        for (int n = 0; n < 6; n++) begin
            a = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
            do_write(a, d, 8'(n));
            lines.push_back(a);
        end
        for (int n = 0; n < 10; n++) begin
            a = lines[$urandom_range(0, lines.size() - 1)];
            a = (a & ~64'h3f) | 64'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) a = a + 64'(MEM_WORDS) * 64'd8 * 64'($urandom_range(1, 5));
            do_read(a, 8'(8'h40 + n));
        end

        // Reset while beat 4 is on the bus, then a clean re-read.
        issue_read(64'h1000, 8'h09);
        k = 0;
        while (beats_done < 4 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("midreset_reached_beat4", 64'(beats_done >= 4), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs();
        sb.delete();
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", 64'(bus.bus_respcyc), 64'd0);
        do_read(64'h1000, 8'h0a);

`ifdef SYSBUS_PROTO_CHECK_EN
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("proto_after_reset", 64'(proto_err), 64'd0);
        force_ack = 1'b1;
        @(posedge clk); #1;
        force_ack = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("proto_sticky", 64'(proto_err), 64'd1);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("proto_cleared", 64'(proto_err), 64'd0);
`endif

        check("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
